// File: rtl/mips_pkg.sv
// Shared definitions for the fetch stage: word width, instruction field
// positions, fetch state encoding and the all-zero halt word.
package mips_pkg;

    localparam int WORD_W     = 32;
    localparam int OPCODE_MSB = 31;
    localparam int OPCODE_LSB = 26;
    localparam int IMM_MSB    = 15;
    localparam int IMM_LSB    = 0;
    localparam int JIDX_MSB   = 25;
    localparam int JIDX_LSB   = 0;

    localparam logic [WORD_W-1:0] NOP_WORD = 32'h0000_0000;

    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } fetch_state_t;

endpackage

// File: rtl/pc_fetch_unit_next_pc_sel.sv
// Combinational next-PC priority mux (jr > j > branch > sequential) with
// the target adders and the alignment / range checks on the chosen target.
module next_pc_sel
    import mips_pkg::*;
#(
    parameter int MEM_WORDS = 256
) (
    input  logic [WORD_W-1:0] pc_i,
    input  logic              branch_taken_i,
    input  logic [15:0]       branch_imm_i,
    input  logic              jump_i,
    input  logic [25:0]       jump_index_i,
    input  logic              jump_reg_i,
    input  logic [WORD_W-1:0] jr_target_i,
    output logic [WORD_W-1:0] pc_plus4_o,
    output logic [WORD_W-1:0] next_pc_o,
    output logic              misaligned_o,
    output logic              out_of_range_o
);

    // One extra bit so the byte limit itself can never wrap to zero.
    localparam logic [WORD_W:0] PC_LIMIT = 33'(MEM_WORDS) * 33'd4;

    logic [WORD_W-1:0] branch_target;
    logic [WORD_W-1:0] jump_target;

    assign pc_plus4_o    = pc_i + 32'd4;
    assign branch_target = pc_plus4_o + {{14{branch_imm_i[15]}}, branch_imm_i, 2'b00};
    assign jump_target   = {pc_plus4_o[31:28], jump_index_i, 2'b00};

    always_comb begin
        next_pc_o = pc_plus4_o;
        if (jump_reg_i) begin
            next_pc_o = jr_target_i;
        end else if (jump_i) begin
            next_pc_o = jump_target;
        end else if (branch_taken_i) begin
            next_pc_o = branch_target;
        end
    end

    assign misaligned_o   = (next_pc_o[1:0] != 2'b00);
    assign out_of_range_o = ({1'b0, next_pc_o} >= PC_LIMIT);

endmodule

// File: rtl/pc_fetch_unit.sv
// Program counter stage feeding instruction memory: holds PC, run/halt
// state, fault flag and a saturating retired-instruction counter.
module pc_fetch_unit
    import mips_pkg::*;
#(
    parameter logic [WORD_W-1:0] RESET_PC     = 32'h0000_0000,
    parameter int                MEM_WORDS    = 256,
    parameter int                HALT_ON_ZERO = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall,
    input  logic              branch_taken,
    input  logic [15:0]       branch_imm,
    input  logic              jump,
    input  logic [25:0]       jump_index,
    input  logic              jump_reg,
    input  logic [WORD_W-1:0] jr_target,
    input  logic [WORD_W-1:0] instruction,
    output logic [WORD_W-1:0] pc,
    output logic [WORD_W-1:0] pc_plus4,
    output logic              halted,
    output logic              fault,
    output logic [WORD_W-1:0] retired_count
);

    fetch_state_t      state_q, state_d;
    logic [WORD_W-1:0] pc_q, pc_d;
    logic [WORD_W-1:0] count_q, count_d;
    logic              fault_q, fault_d;

    logic [WORD_W-1:0] next_pc;
    logic              misaligned;
    logic              out_of_range;
    logic [WORD_W-1:0] count_inc;
    logic              zero_halt;

    next_pc_sel #(
        .MEM_WORDS(MEM_WORDS)
    ) u_next_pc_sel (
        .pc_i          (pc_q),
        .branch_taken_i(branch_taken),
        .branch_imm_i  (branch_imm),
        .jump_i        (jump),
        .jump_index_i  (jump_index),
        .jump_reg_i    (jump_reg),
        .jr_target_i   (jr_target),
        .pc_plus4_o    (pc_plus4),
        .next_pc_o     (next_pc),
        .misaligned_o  (misaligned),
        .out_of_range_o(out_of_range)
    );

    assign count_inc = (count_q == '1) ? count_q : count_q + 32'd1;
    assign zero_halt = (HALT_ON_ZERO != 0) && (instruction == NOP_WORD);

    // A faulting target still retires the instruction that produced it,
    // whereas the zero word is never retired.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        count_d = count_q;
        fault_d = fault_q;
        if (state_q == RUN && !stall) begin
            if (zero_halt) begin
                state_d = HALT;
            end else if (misaligned || out_of_range) begin
                state_d = HALT;
                fault_d = 1'b1;
                count_d = count_inc;
            end else begin
                pc_d    = next_pc;
                count_d = count_inc;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= RUN;
            pc_q    <= RESET_PC;
            count_q <= '0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            count_q <= count_d;
            fault_q <= fault_d;
        end
    end

    assign pc            = pc_q;
    assign halted        = (state_q == HALT);
    assign fault         = fault_q;
    assign retired_count = count_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Self-checking bench for pc_fetch_unit: directed scenarios followed by
// randomized control traffic, checked against an arithmetic fetch model.
module tb_pc_fetch_unit;

    localparam logic [31:0] RESET_PC  = 32'h0000_0000;
    localparam int          MEM_WORDS = 256;
    localparam logic [31:0] GOOD_WORD = 32'h2108_0001;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        stall = 1'b0;
    logic        branchTaken = 1'b0;
    logic [15:0] branchImm = '0;
    logic        jump = 1'b0;
    logic [25:0] jumpIndex = '0;
    logic        jumpReg = 1'b0;
    logic [31:0] jrTarget = '0;
    logic [31:0] instruction = GOOD_WORD;
    logic [31:0] pc;
    logic [31:0] pcPlus4;
    logic        halted;
    logic        fault;
    logic [31:0] retiredCount;

    int testCount = 0;
    int errorCount = 0;

    longint mPc = 0;
    longint mCount = 0;
    bit     mHalt = 0;
    bit     mFault = 0;

    pc_fetch_unit #(
        .RESET_PC    (RESET_PC),
        .MEM_WORDS   (MEM_WORDS),
        .HALT_ON_ZERO(1)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .stall        (stall),
        .branch_taken (branchTaken),
        .branch_imm   (branchImm),
        .jump         (jump),
        .jump_index   (jumpIndex),
        .jump_reg     (jumpReg),
        .jr_target    (jrTarget),
        .instruction  (instruction),
        .pc           (pc),
        .pc_plus4     (pcPlus4),
        .halted       (halted),
        .fault        (fault),
        .retired_count(retiredCount)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        testCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
        end
    endtask

    // Reference behaviour of one clock edge, written from the fetch rules.
    task automatic modelEdge();
        longint target;
        longint offset;
        if (reset) begin
            mPc = longint'(RESET_PC);
            mCount = 0;
            mHalt = 0;
            mFault = 0;
        end else if (!mHalt && !stall) begin
            if (instruction == 32'h0) begin
                mHalt = 1;
            end else begin
                if (jumpReg) begin
                    target = longint'(jrTarget);
                end else if (jump) begin
                    target = ((mPc + 4) & 64'hF000_0000) | (longint'(jumpIndex) * 4);
                end else if (branchTaken) begin
                    offset = longint'(branchImm);
                    if (offset >= 32768) offset -= 65536;
                    target = (mPc + 4 + offset * 4 + 64'h1_0000_0000) & 64'hFFFF_FFFF;
                end else begin
                    target = (mPc + 4) & 64'hFFFF_FFFF;
                end
                if (mCount < 64'hFFFF_FFFF) mCount++;
                if ((target % 4) != 0 || target >= MEM_WORDS * 4) begin
                    mHalt = 1;
                    mFault = 1;
                end else begin
                    mPc = target;
                end
            end
        end
    endtask

    task automatic applyStimulus(input string tag, input logic rst, input logic st,
                                 input logic br, input logic [15:0] imm,
                                 input logic jmp, input logic [25:0] idx,
                                 input logic jr, input logic [31:0] jrt,
                                 input logic [31:0] instr);
        reset = rst;
        stall = st;
        branchTaken = br;
        branchImm = imm;
        jump = jmp;
        jumpIndex = idx;
        jumpReg = jr;
        jrTarget = jrt;
        instruction = instr;
        modelEdge();
        @(posedge clk);
        #1;
        checkOutput({tag, ".pc"}, pc, 32'(mPc));
        checkOutput({tag, ".pc_plus4"}, pcPlus4, 32'((mPc + 4) & 64'hFFFF_FFFF));
        checkOutput({tag, ".halted"}, 32'(halted), 32'(mHalt));
        checkOutput({tag, ".fault"}, 32'(fault), 32'(mFault));
        checkOutput({tag, ".count"}, retiredCount, 32'(mCount));
    endtask

    task automatic doReset();
        applyStimulus("reset", 1, 0, 0, 0, 0, 0, 0, 0, GOOD_WORD);
    endtask

    task automatic doSeq(input string tag, input int n);
        for (int i = 0; i < n; i++) applyStimulus(tag, 0, 0, 0, 0, 0, 0, 0, 0, GOOD_WORD);
    endtask

    initial begin
        @(posedge clk);
        #1;
        doReset();
        doSeq("seq", 3);
        checkOutput("seq.pc12", pc, 32'd12);
        checkOutput("seq.count3", retiredCount, 32'd3);

        doReset();
        doSeq("toPc8", 2);
        applyStimulus("brBack", 0, 0, 1, 16'hFFFE, 0, 0, 0, 0, GOOD_WORD);
        checkOutput("brBack.pc4", pc, 32'd4);
        applyStimulus("brFwd", 0, 0, 1, 16'h0001, 0, 0, 0, 0, GOOD_WORD);
        checkOutput("brFwd.pc12", pc, 32'd12);
        applyStimulus("jmp", 0, 0, 0, 0, 1, 26'h6, 0, 0, GOOD_WORD);
        checkOutput("jmp.pc24", pc, 32'd24);
        applyStimulus("jmpWins", 0, 0, 1, 16'h0005, 1, 26'h0, 0, 0, GOOD_WORD);
        checkOutput("jmpWins.pc0", pc, 32'd0);

        doSeq("toPc8b", 2);
        applyStimulus("jrMisalign", 0, 0, 0, 0, 0, 0, 1, 32'h1E, GOOD_WORD);
        checkOutput("jrMisalign.halt", {31'b0, halted, 1'b0} | 32'(fault), 32'd3);
        applyStimulus("haltFrozen", 0, 0, 1, 16'h4, 1, 26'h3, 0, 0, GOOD_WORD);
        applyStimulus("haltStall", 0, 1, 0, 0, 0, 0, 0, 0, GOOD_WORD);
        doReset();
        doSeq("toPc8c", 2);
        applyStimulus("jrRange", 0, 0, 0, 0, 0, 0, 1, 32'h400, GOOD_WORD);
        checkOutput("jrRange.pc8", pc, 32'd8);

        doReset();
        doSeq("toPc16", 4);
        applyStimulus("stall1", 0, 1, 1, 16'h10, 0, 0, 0, 0, GOOD_WORD);
        applyStimulus("stall2", 0, 1, 0, 0, 1, 26'h9, 0, 0, GOOD_WORD);
        checkOutput("stall.pc16", pc, 32'd16);
        doSeq("toPc20", 1);
        applyStimulus("zeroStalled", 0, 1, 0, 0, 0, 0, 0, 0, 32'h0);
        applyStimulus("zeroHalt", 0, 0, 0, 0, 0, 0, 0, 0, 32'h0);
        checkOutput("zeroHalt.pc20", pc, 32'd20);
        checkOutput("zeroHalt.count5", retiredCount, 32'd5);
        applyStimulus("resetInHalt", 1, 1, 1, 16'h1, 1, 26'h1, 1, 32'h1, GOOD_WORD);
        checkOutput("resetInHalt.pc", pc, RESET_PC);

        applyStimulus("jmpLast", 0, 0, 0, 0, 1, 26'(MEM_WORDS - 1), 0, 0, GOOD_WORD);
        applyStimulus("fallOff", 0, 0, 0, 0, 0, 0, 0, 0, GOOD_WORD);
        checkOutput("fallOff.fault", 32'(fault), 32'd1);

        doReset();
        for (int i = 0; i < 600; i++) begin
            logic [31:0] jrt;
            jrt = ($urandom_range(0, 9) == 0) ? $urandom : 32'($urandom_range(0, 300)) << 2;
            applyStimulus("rand",
                          $urandom_range(0, 39) == 0,
                          $urandom_range(0, 5) == 0,
                          $urandom_range(0, 3) == 0,
                          16'($urandom),
                          $urandom_range(0, 7) == 0,
                          26'($urandom_range(0, 300)),
                          $urandom_range(0, 9) == 0,
                          jrt,
                          ($urandom_range(0, 29) == 0) ? 32'h0 : ($urandom | 32'h1));
        end

        $display("[TB] %0d tests run, %0d failed", testCount, errorCount);
        $finish;
    end

endmodule
